bt_cmd_parser: RTL and testbench
================================

BT_CMD_PARSER -- requirements
Module: bt_cmd_parser

Interface
REQ-001 Parameters SHALL be:
- CLK_HZ, default 50000000, system clock frequency in Hz.
- TIMEOUT_MS, default 10, maximum gap between bytes inside a frame.

REQ-002 Ports SHALL be, in this order:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  acknowledge byte presented to the UART transmitter.
- tx_en  out  1  single-cycle transmit request.
- cmd_valid  out  1  single-cycle strobe; a frame was accepted.
- cmd_code  out  8  command letter of the last accepted frame.
- cmd_arg  out  8  argument byte of the last accepted frame.
- start  out  1  sticky run flag.
- frame_err  out  1  single-cycle strobe; a frame was rejected.

Function
REQ-003 A frame SHALL be five bytes: '#' (0x23), command letter 'A'-'Z', hex high digit, hex low digit, ';' (0x3B).
REQ-004 Hex digits SHALL accept '0'-'9', 'A'-'F' and 'a'-'f'; any other byte in a digit position SHALL be an error.
REQ-005 The FSM SHALL have states IDLE, CMD, ARG_HI, ARG_LO and TERM, and SHALL advance only on cycles where rx_valid=1.
- IDLE: '#' -> CMD; any other byte is ignored, with no error.
- CMD: letter -> ARG_HI.
- ARG_HI: hex digit -> ARG_LO.
- ARG_LO: hex digit -> TERM.
- TERM: ';' -> IDLE, frame accepted.
REQ-006 In CMD, ARG_HI, ARG_LO or TERM, a '#' byte SHALL restart the frame (go to CMD) with no error and no ack.
REQ-007 In CMD, ARG_HI, ARG_LO or TERM, any other invalid byte SHALL pulse frame_err, queue ack 'E' (0x45) and return to IDLE.
REQ-008 On acceptance, in the cycle after the ';' strobe:
- cmd_valid SHALL pulse for exactly one cycle;
- cmd_code and cmd_arg SHALL update at the same time and then hold until the next accepted frame;
- ack 'D' (0x44) SHALL be queued.
REQ-009 cmd_arg SHALL equal {high nibble, low nibble}; for example "#B7f;" gives cmd_arg=0x7F.
REQ-010 An accepted frame with cmd_code='A' SHALL set start=1; start SHALL clear only on reset.
REQ-011 Ack queue: a single pending register.
- tx_en SHALL pulse for one cycle, with tx_data valid, on the first cycle where an ack is pending and tx_busy=0.
- Earliest tx_en SHALL be one cycle after queueing.
- A new ack queued while one is still pending SHALL overwrite it (latest wins).
- tx_data SHALL hold its value between requests.
REQ-012 tx_en SHALL never be asserted in a cycle where tx_busy=1.
REQ-013 If rx_valid coincides with an ack being issued, no received byte SHALL be lost.

Reset
REQ-014 resetn=0 SHALL, asynchronously:
- set the FSM to IDLE;
- clear the pending ack and the timeout counter;
- drive tx_data=0x00 and cmd_code=0x00, cmd_arg=0x00;
- drive tx_en=0, cmd_valid=0, start=0, frame_err=0.
REQ-015 A reset in the middle of a frame SHALL discard the partial frame; the next frame SHALL be parsed from IDLE normally.

Configuration
REQ-016 With macro BT_CMD_TIMEOUT_EN defined, the inter-byte timeout SHALL be compiled in:
- a counter SHALL count while the FSM is outside IDLE and SHALL restart on each rx_valid;
- on reaching CLK_HZ/1000*TIMEOUT_MS cycles it SHALL pulse frame_err, queue 'E' and return to IDLE;
- the counter width SHALL be derived with $clog2.
REQ-017 Without BT_CMD_TIMEOUT_EN, there SHALL be no counter logic, and a partial frame SHALL wait indefinitely.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Bytes "#A05;", tx_busy=0 -> cmd_valid 1 cycle with cmd_code=0x41, cmd_arg=0x05; start=1; one tx_en with tx_data=0x44.
- Bytes "#Cg1;" -> frame_err pulse on 'g'; tx_data=0x45; no cmd_valid; start unchanged.
- Bytes "#B1#Bff;" -> a single cmd_valid with cmd_arg=0xFF; no frame_err.
- Hold tx_busy=1 for 200 cycles after "#D10;" -> no tx_en during busy; exactly one tx_en with 0x44 one cycle after tx_busy falls.
- Drop resetn after "#A0" -> all outputs at reset values; then "#E22;" -> cmd_arg=0x22 and start=0.
- With BT_CMD_TIMEOUT_EN, CLK_HZ=1000000, TIMEOUT_MS=1, send "#A" then idle 1000 cycles -> frame_err pulse and ack 0x45; without the macro -> no response.

Source files
------------

// File: rtl/bt_cmd_parser.sv
// ASCII command-frame parser "#<A-Z><hex><hex>;" with a single-entry D/E acknowledge queue.
// Define BT_CMD_TIMEOUT_EN to compile in the inter-byte timeout.
module bt_cmd_parser #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       start,
  output logic       frame_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ARG_HI = 3'd2;
  localparam logic [2:0] ARG_LO = 3'd3;
  localparam logic [2:0] TERM   = 3'd4;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] ACK_OK  = 8'h44;
  localparam logic [7:0] ACK_ERR = 8'h45;

  logic [2:0] state, state_nxt;
  logic [7:0] code_lat;
  logic [3:0] hi_lat, lo_lat;
  logic       accept, err;
  logic       hex_ok;
  logic [3:0] hex_nib;
  logic       is_letter;
  logic       tmo_hit;
  logic       ack_pend;
  logic [7:0] ack_byte;

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      hex_nib = rx_data[3:0];
    else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
             (rx_data >= 8'h61 && rx_data <= 8'h66))
      hex_nib = rx_data[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  assign is_letter = (rx_data >= 8'h41) && (rx_data <= 8'h5A);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err       = 1'b0;
    if (rx_valid) begin
      if (rx_data == CH_HASH) begin
        state_nxt = CMD;
      end else begin
        case (state)
          CMD:     if (is_letter) state_nxt = ARG_HI; else err = 1'b1;
          ARG_HI:  if (hex_ok) state_nxt = ARG_LO; else err = 1'b1;
          ARG_LO:  if (hex_ok) state_nxt = TERM; else err = 1'b1;
          TERM: begin
            if (rx_data == CH_SEMI) begin
              state_nxt = IDLE;
              accept    = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      err = 1'b1;
    end
    if (err)
      state_nxt = IDLE;
  end

`ifdef BT_CMD_TIMEOUT_EN
  localparam int unsigned TMO_RAW = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned TMO_CYC = (TMO_RAW < 1) ? 1 : TMO_RAW;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the TMO_CYC-th consecutive byte-free cycle inside a frame.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      tmo_cnt <= '0;
    else if (state == IDLE || rx_valid || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      code_lat  <= '0;
      hi_lat    <= '0;
      lo_lat    <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= accept;
      frame_err <= err;
      if (rx_valid) begin
        if (state == CMD)    code_lat <= rx_data;
        if (state == ARG_HI) hi_lat   <= hex_nib;
        if (state == ARG_LO) lo_lat   <= hex_nib;
      end
      if (accept) begin
        cmd_code <= code_lat;
        cmd_arg  <= {hi_lat, lo_lat};
        if (code_lat == 8'h41)
          start <= 1'b1;
      end
    end
  end

  // Issue and re-queue can share an edge; the newly queued ack survives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_pend <= 1'b0;
      ack_byte <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_en <= 1'b0;
      if (ack_pend && !tx_busy) begin
        tx_en    <= 1'b1;
        tx_data  <= ack_byte;
        ack_pend <= 1'b0;
      end
      if (accept || err) begin
        ack_pend <= 1'b1;
        ack_byte <= accept ? ACK_OK : ACK_ERR;
      end
    end
  end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Directed bench for bt_cmd_parser: frames, errors, restart, busy hold, ack overwrite, reset, timeout.
module tb_bt_cmd_parser;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       start;
  logic       frame_err;

  bt_cmd_parser #(.CLK_HZ(1000000), .TIMEOUT_MS(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_arg  (cmd_arg),
    .start    (start),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  int unsigned cv_n = 0, fe_n = 0, te_n = 0, viol_n = 0;
  logic [7:0]  last_tx = '0;
  int unsigned cv0, fe0, te0;

  always @(negedge clk) begin
    if (resetn) begin
      if (cmd_valid) cv_n++;
      if (frame_err) fe_n++;
      if (tx_en) begin
        te_n++;
        last_tx = tx_data;
        if (tx_busy) viol_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    cv0 = cv_n;
    fe0 = fe_n;
    te0 = te_n;
  endtask

  // Callers are positioned 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " tx_data"},   tx_data,   32'h00);
    check({pfx, " tx_en"},     tx_en,     32'h0);
    check({pfx, " cmd_valid"}, cmd_valid, 32'h0);
    check({pfx, " cmd_code"},  cmd_code,  32'h00);
    check({pfx, " cmd_arg"},   cmd_arg,   32'h00);
    check({pfx, " start"},     start,     32'h0);
    check({pfx, " frame_err"}, frame_err, 32'h0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1 check_reset_outputs("por");
    idle(3);
    resetn = 1'b1;
    idle(2);

    // valid frame with start command
    snap();
    send_str("#A05;");
    idle(4);
    check("a05 cmd_valid count", cv_n - cv0, 1);
    check("a05 cmd_code", cmd_code, 32'h41);
    check("a05 cmd_arg", cmd_arg, 32'h05);
    check("a05 start", start, 1);
    check("a05 tx_en count", te_n - te0, 1);
    check("a05 tx_data", last_tx, 32'h44);
    check("a05 frame_err count", fe_n - fe0, 0);

    // bad hex digit
    snap();
    send_str("#Cg1;");
    idle(4);
    check("cg1 frame_err count", fe_n - fe0, 1);
    check("cg1 cmd_valid count", cv_n - cv0, 0);
    check("cg1 tx_en count", te_n - te0, 1);
    check("cg1 tx_data", last_tx, 32'h45);
    check("cg1 start", start, 1);
    check("cg1 cmd_code held", cmd_code, 32'h41);

    // restart mid-frame, lowercase hex
    snap();
    send_str("#B1#Bff;");
    idle(4);
    check("restart cmd_valid count", cv_n - cv0, 1);
    check("restart cmd_arg", cmd_arg, 32'hFF);
    check("restart cmd_code", cmd_code, 32'h42);
    check("restart frame_err count", fe_n - fe0, 0);

    // transmitter busy for 200 cycles
    snap();
    tx_busy = 1'b1;
    send_str("#D10;");
    idle(200);
    check("busy tx_en count", te_n - te0, 0);
    check("busy cmd_arg", cmd_arg, 32'h10);
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy release same cycle tx_en", tx_en, 0);
    @(negedge clk);
    check("busy release next cycle tx_en", tx_en, 1);
    check("busy release tx_data", tx_data, 32'h44);
    @(posedge clk);
    #1;
    idle(3);
    check("busy release tx_en count", te_n - te0, 1);

    // later ack overwrites pending one
    snap();
    tx_busy = 1'b1;
    send_str("#F00;#1");
    idle(5);
    check("overwrite cmd_valid count", cv_n - cv0, 1);
    check("overwrite frame_err count", fe_n - fe0, 1);
    tx_busy = 1'b0;
    idle(4);
    check("overwrite tx_en count", te_n - te0, 1);
    check("overwrite tx_data", last_tx, 32'h45);

    // reset mid-frame
    send_str("#A0");
    resetn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(1);
    snap();
    send_str("#E22;");
    idle(4);
    check("post-reset cmd_valid count", cv_n - cv0, 1);
    check("post-reset cmd_arg", cmd_arg, 32'h22);
    check("post-reset cmd_code", cmd_code, 32'h45);
    check("post-reset start", start, 0);

    // inter-byte gap of 1100 cycles (limit is 1000)
    snap();
    send_str("#A");
    idle(1100);
`ifdef BT_CMD_TIMEOUT_EN
    check("timeout frame_err count", fe_n - fe0, 1);
    check("timeout tx_en count", te_n - te0, 1);
    check("timeout tx_data", last_tx, 32'h45);
`else
    check("no-timeout frame_err count", fe_n - fe0, 0);
    check("no-timeout tx_en count", te_n - te0, 0);
`endif
    check("gap cmd_valid count", cv_n - cv0, 0);
    check("gap start", start, 0);

    snap();
    send_str("#B12;");
    idle(4);
    check("after gap cmd_valid count", cv_n - cv0, 1);
    check("after gap cmd_arg", cmd_arg, 32'h12);

    check("tx_en while busy", viol_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
